pipe_hazard_controller: RTL and testbench

Parametrised successor to the 5-stage pipeline control path: decodes opcode/funct in DEC and carries the control bundle through EXE/MEM/WB registers. Adds the behaviour the plain control pipeline lacks:
- load-use and RAW stall detection
- EXE-stage forwarding selects
- jump decode
- flush of wrong-path instructions on a taken branch

It sits beside the datapath and drives every pipeline-register enable, clear and mux select.

---
 rtl/pipe_ctrl_pkg.sv | 64 ++++++
 rtl/pipe_hazard_controller_hazard_unit.sv | 79 +++++++
 rtl/pipe_hazard_controller.sv | 188 ++++++++++++++++++
 tb/tb_pipe_hazard_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipelined control path: opcodes, functs, ALU codes,
// the ALU-op enum and the ID/EX control bundle.
package pipe_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_e;

   typedef struct packed {
      logic       regwrite;
      logic       memtoreg;
      logic       memwrite;
      logic       branch;
      logic [2:0] alucontrol;
      logic       alusrc;
      logic       regdst;
   } idex_ctrl_t;

   function automatic logic [2:0] alu_decode(input aluop_e aluop, input logic [5:0] funct);
      logic [2:0] alu;
      case (aluop)
         ALUOP_ADD: alu = ALU_ADD;
         ALUOP_SUB: alu = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu = ALU_ADD;
               FN_SUB:  alu = ALU_SUB;
               FN_AND:  alu = ALU_AND;
               FN_OR:   alu = ALU_OR;
               FN_SLT:  alu = ALU_SLT;
               default: alu = ALU_AND;
            endcase
         end
         default: alu = ALU_AND;
      endcase
      return alu;
   endfunction

endpackage

// File: rtl/pipe_hazard_controller_hazard_unit.sv
// Stall, flush and forward-select generation from the current stage registers
// and the DEC source registers; purely combinational.
module hazard_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W  = 5,
   parameter bit EN_FWD = 1'b1
) (
   input  logic             reset,
   input  logic [REG_W-1:0] rs_DEC,
   input  logic [REG_W-1:0] rt_DEC,
   input  logic             jump_DEC,
   input  logic [REG_W-1:0] rs_EXE,
   input  logic [REG_W-1:0] rt_EXE,
   input  logic             regwrite_EXE,
   input  logic             memtoreg_EXE,
   input  logic [REG_W-1:0] writereg_EXE,
   input  logic             regwrite_MEM,
   input  logic             branch_MEM,
   input  logic             zero_MEM,
   input  logic [REG_W-1:0] writereg_MEM,
   input  logic             regwrite_WB,
   input  logic [REG_W-1:0] writereg_WB,
   output logic             stall,
   output logic             flush_DEC,
   output logic             flush_EXE,
   output logic             pcsrc_MEM,
   output logic [1:0]       forwarda_EXE,
   output logic [1:0]       forwardb_EXE
);

   logic lwstall_s;
   logic rawstall_s;

   // Register 0 is hard-wired, so it never creates a dependency.
   function automatic logic reg_hit(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
      return (src != {REG_W{1'b0}}) && (src == dst);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
      logic [1:0] sel;
      if (regwrite_MEM && reg_hit(src, writereg_MEM)) begin
         sel = FWD_MEM;
      end else if (regwrite_WB && reg_hit(src, writereg_WB)) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_RF;
      end
      return sel;
   endfunction

   // Hazard detection and the resulting stall/flush controls
   always_comb begin
      lwstall_s = memtoreg_EXE & regwrite_EXE &
                  (reg_hit(rs_DEC, writereg_EXE) | reg_hit(rt_DEC, writereg_EXE));
      if (EN_FWD) begin
         rawstall_s = 1'b0;
      end else begin
         rawstall_s = (regwrite_EXE & (reg_hit(rs_DEC, writereg_EXE) | reg_hit(rt_DEC, writereg_EXE))) |
                      (regwrite_MEM & (reg_hit(rs_DEC, writereg_MEM) | reg_hit(rt_DEC, writereg_MEM)));
      end
      pcsrc_MEM = branch_MEM & zero_MEM & ~reset;
      stall     = (lwstall_s | rawstall_s) & ~pcsrc_MEM & ~reset;
      flush_DEC = (pcsrc_MEM | (jump_DEC & ~stall)) & ~reset;
      flush_EXE = stall | pcsrc_MEM;
   end

   // Forward selects; MEM result takes priority over WB
   always_comb begin
      if (EN_FWD && !reset) begin
         forwarda_EXE = fwd_sel(rs_EXE);
         forwardb_EXE = fwd_sel(rt_EXE);
      end else begin
         forwarda_EXE = FWD_RF;
         forwardb_EXE = FWD_RF;
      end
   end

endmodule

// File: rtl/pipe_hazard_controller.sv
// Five-stage control path: decodes in DEC, carries control bits through
// ID/EX, EX/MEM and MEM/WB, and delegates hazards to hazard_unit.
module pipe_hazard_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W  = 5,
   parameter bit EN_FWD = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode_DEC,
   input  logic [5:0]       funct_DEC,
   input  logic [REG_W-1:0] rs_DEC,
   input  logic [REG_W-1:0] rt_DEC,
   input  logic [REG_W-1:0] writereg_EXE,
   input  logic [REG_W-1:0] writereg_MEM,
   input  logic [REG_W-1:0] writereg_WB,
   input  logic             zero_MEM,
   output logic             alusrc_EXE,
   output logic             regdst_EXE,
   output logic [2:0]       alucontrol_EXE,
   output logic             memwrite_MEM,
   output logic             pcsrc_MEM,
   output logic             regwrite_WB,
   output logic             memtoreg_WB,
   output logic             jump_DEC,
   output logic             stall_FET,
   output logic             stall_DEC,
   output logic             flush_DEC,
   output logic [1:0]       forwarda_EXE,
   output logic [1:0]       forwardb_EXE
);

   idex_ctrl_t       dec_ctrl_s;
   aluop_e           aluop_s;
   logic             alu_used_s;
   logic             jump_s;
   logic             stall_s;
   logic             flush_exe_s;
   logic             pcsrc_s;

   idex_ctrl_t       ex_ctrl_d, ex_ctrl_q;
   logic [REG_W-1:0] rs_ex_d, rs_ex_q, rt_ex_d, rt_ex_q;
   logic             regwrite_mem_d, regwrite_mem_q;
   logic             memtoreg_mem_d, memtoreg_mem_q;
   logic             memwrite_mem_d, memwrite_mem_q;
   logic             branch_mem_d, branch_mem_q;
   logic             regwrite_wb_d, regwrite_wb_q;
   logic             memtoreg_wb_d, memtoreg_wb_q;

   // Main decode; unknown opcodes and j leave every datapath control at 0
   always_comb begin
      dec_ctrl_s = '0;
      aluop_s    = ALUOP_ADD;
      alu_used_s = 1'b0;
      jump_s     = 1'b0;
      case (opcode_DEC)
         OP_RTYPE: begin
            dec_ctrl_s.regwrite = 1'b1;
            dec_ctrl_s.regdst   = 1'b1;
            aluop_s             = ALUOP_FUNCT;
            alu_used_s          = 1'b1;
         end
         OP_LW: begin
            dec_ctrl_s.regwrite = 1'b1;
            dec_ctrl_s.alusrc   = 1'b1;
            dec_ctrl_s.memtoreg = 1'b1;
            alu_used_s          = 1'b1;
         end
         OP_SW: begin
            dec_ctrl_s.alusrc   = 1'b1;
            dec_ctrl_s.memwrite = 1'b1;
            alu_used_s          = 1'b1;
         end
         OP_BEQ: begin
            dec_ctrl_s.branch = 1'b1;
            aluop_s           = ALUOP_SUB;
            alu_used_s        = 1'b1;
         end
         OP_ADDI: begin
            dec_ctrl_s.regwrite = 1'b1;
            dec_ctrl_s.alusrc   = 1'b1;
            alu_used_s          = 1'b1;
         end
         OP_J: begin
            jump_s = 1'b1;
         end
         default: begin
            dec_ctrl_s = '0;
         end
      endcase
      if (alu_used_s) begin
         dec_ctrl_s.alucontrol = alu_decode(aluop_s, funct_DEC);
      end else begin
         dec_ctrl_s.alucontrol = ALU_AND;
      end
   end

   hazard_unit #(
      .REG_W  (REG_W),
      .EN_FWD (EN_FWD)
   ) u_hazard (
      .reset        (reset),
      .rs_DEC       (rs_DEC),
      .rt_DEC       (rt_DEC),
      .jump_DEC     (jump_s),
      .rs_EXE       (rs_ex_q),
      .rt_EXE       (rt_ex_q),
      .regwrite_EXE (ex_ctrl_q.regwrite),
      .memtoreg_EXE (ex_ctrl_q.memtoreg),
      .writereg_EXE (writereg_EXE),
      .regwrite_MEM (regwrite_mem_q),
      .branch_MEM   (branch_mem_q),
      .zero_MEM     (zero_MEM),
      .writereg_MEM (writereg_MEM),
      .regwrite_WB  (regwrite_wb_q),
      .writereg_WB  (writereg_WB),
      .stall        (stall_s),
      .flush_DEC    (flush_DEC),
      .flush_EXE    (flush_exe_s),
      .pcsrc_MEM    (pcsrc_s),
      .forwarda_EXE (forwarda_EXE),
      .forwardb_EXE (forwardb_EXE)
   );

   // Next-state of the stage registers; a cleared stage becomes an all-zero bubble
   always_comb begin
      if (flush_exe_s) begin
         ex_ctrl_d = '0;
         rs_ex_d   = {REG_W{1'b0}};
         rt_ex_d   = {REG_W{1'b0}};
      end else begin
         ex_ctrl_d = dec_ctrl_s;
         rs_ex_d   = rs_DEC;
         rt_ex_d   = rt_DEC;
      end
      if (pcsrc_s) begin
         regwrite_mem_d = 1'b0;
         memtoreg_mem_d = 1'b0;
         memwrite_mem_d = 1'b0;
         branch_mem_d   = 1'b0;
      end else begin
         regwrite_mem_d = ex_ctrl_q.regwrite;
         memtoreg_mem_d = ex_ctrl_q.memtoreg;
         memwrite_mem_d = ex_ctrl_q.memwrite;
         branch_mem_d   = ex_ctrl_q.branch;
      end
      regwrite_wb_d = regwrite_mem_q;
      memtoreg_wb_d = memtoreg_mem_q;
   end

   // Stage registers
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_ctrl_q      <= '0;
         rs_ex_q        <= {REG_W{1'b0}};
         rt_ex_q        <= {REG_W{1'b0}};
         regwrite_mem_q <= 1'b0;
         memtoreg_mem_q <= 1'b0;
         memwrite_mem_q <= 1'b0;
         branch_mem_q   <= 1'b0;
         regwrite_wb_q  <= 1'b0;
         memtoreg_wb_q  <= 1'b0;
      end else begin
         ex_ctrl_q      <= ex_ctrl_d;
         rs_ex_q        <= rs_ex_d;
         rt_ex_q        <= rt_ex_d;
         regwrite_mem_q <= regwrite_mem_d;
         memtoreg_mem_q <= memtoreg_mem_d;
         memwrite_mem_q <= memwrite_mem_d;
         branch_mem_q   <= branch_mem_d;
         regwrite_wb_q  <= regwrite_wb_d;
         memtoreg_wb_q  <= memtoreg_wb_d;
      end
   end

   assign alusrc_EXE     = ex_ctrl_q.alusrc;
   assign regdst_EXE     = ex_ctrl_q.regdst;
   assign alucontrol_EXE = ex_ctrl_q.alucontrol;
   assign memwrite_MEM   = memwrite_mem_q;
   assign pcsrc_MEM      = pcsrc_s;
   assign regwrite_WB    = regwrite_wb_q;
   assign memtoreg_WB    = memtoreg_wb_q;
   assign jump_DEC       = jump_s;
   assign stall_FET      = stall_s;
   assign stall_DEC      = stall_s;

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Drives one forwarding and one non-forwarding controller with the same stream
// and checks both every cycle against a stage-list model, plus directed literals.
module tb_pipe_hazard_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = 6'h3f, fn = 6'h00;
   logic [4:0] rs = 5'd0, rt = 5'd0, we = 5'd0, wm = 5'd0, ww = 5'd0;
   logic       zero = 1'b0;

   logic [1:0] alusrc_e, regdst_e, memwrite_m, pcsrc_m, regwrite_w, memtoreg_w;
   logic [1:0] jump_d, stall_f, stall_d, flush_d;
   logic [2:0] aluc_e [2];
   logic [1:0] fa_e [2];
   logic [1:0] fb_e [2];

   int n_vec = 0, n_fail = 0, cyc = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      pipe_hazard_controller #(.REG_W(5), .EN_FWD(g == 0)) u_dut (
         .clk(clk), .reset(rst), .opcode_DEC(op), .funct_DEC(fn),
         .rs_DEC(rs), .rt_DEC(rt),
         .writereg_EXE(we), .writereg_MEM(wm), .writereg_WB(ww), .zero_MEM(zero),
         .alusrc_EXE(alusrc_e[g]), .regdst_EXE(regdst_e[g]), .alucontrol_EXE(aluc_e[g]),
         .memwrite_MEM(memwrite_m[g]), .pcsrc_MEM(pcsrc_m[g]),
         .regwrite_WB(regwrite_w[g]), .memtoreg_WB(memtoreg_w[g]),
         .jump_DEC(jump_d[g]), .stall_FET(stall_f[g]), .stall_DEC(stall_d[g]),
         .flush_DEC(flush_d[g]), .forwarda_EXE(fa_e[g]), .forwardb_EXE(fb_e[g])
      );
   end

   // Model: what each stage holds, per instance (0 = forwarding, 1 = no forwarding)
   typedef struct packed {
      logic rw, mtr, mw, br, as, rd;
      logic [2:0] alu;
      logic [4:0] rs, rt;
   } ex_t;
   typedef struct packed { logic rw, mtr, mw, br; } mem_t;
   typedef struct packed { logic rw, mtr; } wb_t;

   ex_t  m_ex  [2];
   mem_t m_mem [2];
   wb_t  m_wb  [2];
   logic st_x  [2];
   logic pc_x  [2];

   function automatic ex_t decode(input logic [5:0] o, input logic [5:0] f,
                                  input logic [4:0] s, input logic [4:0] t);
      ex_t d;
      d = '0;
      case (o)
         6'h00: begin
            d.rw = 1'b1; d.rd = 1'b1;
            case (f)
               6'h20:   d.alu = 3'd2;
               6'h22:   d.alu = 3'd6;
               6'h25:   d.alu = 3'd1;
               6'h2a:   d.alu = 3'd7;
               default: d.alu = 3'd0;
            endcase
         end
         6'h23: begin d.rw = 1'b1; d.as = 1'b1; d.mtr = 1'b1; d.alu = 3'd2; end
         6'h2b: begin d.as = 1'b1; d.mw = 1'b1; d.alu = 3'd2; end
         6'h04: begin d.br = 1'b1; d.alu = 3'd6; end
         6'h08: begin d.rw = 1'b1; d.as = 1'b1; d.alu = 3'd2; end
         default: d = '0;
      endcase
      d.rs = s;
      d.rt = t;
      return d;
   endfunction

   function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
      return (src != 5'd0) && (src == dst);
   endfunction

   function automatic logic [1:0] fwd(input logic en, input logic [4:0] src,
                                      input logic mem_rw, input logic wb_rw);
      if (!en || rst) return 2'b00;
      if (mem_rw && hit(src, wm)) return 2'b10;
      if (wb_rw && hit(src, ww)) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_check();
      for (int i = 0; i < 2; i++) begin
         logic en, lw, raw, pc, st, fl;
         logic [16:0] want, got;
         en  = (i == 0);
         lw  = m_ex[i].mtr && m_ex[i].rw && (hit(rs, we) || hit(rt, we));
         raw = !en && ((m_ex[i].rw && (hit(rs, we) || hit(rt, we))) ||
                       (m_mem[i].rw && (hit(rs, wm) || hit(rt, wm))));
         pc  = m_mem[i].br && zero && !rst;
         st  = (lw || raw) && !pc && !rst;
         fl  = (pc || ((op == 6'h02) && !st)) && !rst;
         st_x[i] = st;
         pc_x[i] = pc;
         want = {m_ex[i].as, m_ex[i].rd, m_ex[i].alu, m_mem[i].mw, pc,
                 m_wb[i].rw, m_wb[i].mtr, (op == 6'h02), st, st, fl,
                 fwd(en, m_ex[i].rs, m_mem[i].rw, m_wb[i].rw),
                 fwd(en, m_ex[i].rt, m_mem[i].rw, m_wb[i].rw)};
         got  = {alusrc_e[i], regdst_e[i], aluc_e[i], memwrite_m[i], pcsrc_m[i],
                 regwrite_w[i], memtoreg_w[i], jump_d[i], stall_f[i], stall_d[i],
                 flush_d[i], fa_e[i], fb_e[i]};
         n_vec++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL outs_inst%0d cycle %0d: got %h want %h", i, cyc, got, want);
         end
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_ex[i] = '0; m_mem[i] = '0; m_wb[i] = '0;
         end else begin
            m_wb[i]  = '{rw: m_mem[i].rw, mtr: m_mem[i].mtr};
            m_mem[i] = pc_x[i] ? '0 : '{rw: m_ex[i].rw, mtr: m_ex[i].mtr, mw: m_ex[i].mw, br: m_ex[i].br};
            m_ex[i]  = (st_x[i] || pc_x[i]) ? '0 : decode(op, fn, rs, rt);
         end
      end
   endtask

   task automatic go(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                     input logic [4:0] t, input logic [4:0] e, input logic [4:0] m,
                     input logic [4:0] w, input logic z, input logic r);
      if (started) begin
         @(posedge clk);
         model_step();
      end
      started = 1'b1;
      @(negedge clk);
      op = o; fn = f; rs = s; rt = t; we = e; wm = m; ww = w; zero = z; rst = r;
      cyc++;
      #1;
      model_check();
   endtask

   task automatic nop(input logic z);
      go(6'h3f, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, z, 1'b0);
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] ops [8];
      logic [5:0] fns [6];
      for (int i = 0; i < 2; i++) begin
         m_ex[i] = '0; m_mem[i] = '0; m_wb[i] = '0; st_x[i] = 1'b0; pc_x[i] = 1'b0;
      end
      ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h23, 6'h3f};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h11};

      // reset state
      go(6'h3f, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      go(6'h3f, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      nop(1'b0);
      chk("reset_regwrite_WB", {7'd0, regwrite_w[0]}, 8'd0);
      chk("reset_alucontrol", {5'd0, aluc_e[0]}, 8'd0);
      chk("reset_fwd_a", {6'd0, fa_e[0]}, 8'd0);

      // add $3,$1,$2 through the pipe
      go(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      nop(1'b0);
      chk("add_alucontrol_EXE", {5'd0, aluc_e[0]}, 8'h02);
      chk("add_regdst_EXE", {7'd0, regdst_e[0]}, 8'd1);
      nop(1'b0);
      nop(1'b0);
      chk("add_regwrite_WB", {7'd0, regwrite_w[0]}, 8'd1);

      // lw $2 then add $4,$2,$5
      go(6'h23, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      go(6'h00, 6'h20, 5'd2, 5'd5, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("lwuse_stall_FET", {7'd0, stall_f[0]}, 8'd1);
      chk("lwuse_stall_DEC", {7'd0, stall_d[0]}, 8'd1);
      go(6'h00, 6'h20, 5'd2, 5'd5, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0);
      chk("lwuse_stall_drops", {7'd0, stall_d[0]}, 8'd0);
      chk("lwuse_bubble", {3'd0, alusrc_e[0], regdst_e[0], aluc_e[0]}, 8'd0);
      go(6'h3f, 6'h00, 5'd0, 5'd0, 5'd4, 5'd0, 5'd2, 1'b0, 1'b0);
      chk("lwuse_fwd_a_WB", {6'd0, fa_e[0]}, 8'h01);
      nop(1'b0); nop(1'b0); nop(1'b0);

      // add $2 then sub $6,$2,$2: forwarding vs stalling instance
      go(6'h00, 6'h20, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      go(6'h00, 6'h22, 5'd2, 5'd2, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("raw_fwd_nostall", {7'd0, stall_d[0]}, 8'd0);
      chk("raw_nofwd_stall1", {7'd0, stall_d[1]}, 8'd1);
      go(6'h00, 6'h22, 5'd2, 5'd2, 5'd6, 5'd2, 5'd0, 1'b0, 1'b0);
      chk("raw_fwd_a_MEM", {6'd0, fa_e[0]}, 8'h02);
      chk("raw_fwd_b_MEM", {6'd0, fb_e[0]}, 8'h02);
      chk("raw_nofwd_stall2", {7'd0, stall_d[1]}, 8'd1);
      chk("raw_nofwd_fwd_a", {6'd0, fa_e[1]}, 8'd0);
      go(6'h00, 6'h22, 5'd2, 5'd2, 5'd6, 5'd6, 5'd2, 1'b0, 1'b0);
      chk("raw_nofwd_stall_end", {7'd0, stall_d[1]}, 8'd0);
      nop(1'b0); nop(1'b0); nop(1'b0);

      // taken beq followed by sw
      go(6'h04, 6'h00, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      go(6'h2b, 6'h00, 5'd1, 5'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      go(6'h2b, 6'h00, 5'd1, 5'd3, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      chk("beq_pcsrc", {7'd0, pcsrc_m[0]}, 8'd1);
      chk("beq_flush_DEC", {7'd0, flush_d[0]}, 8'd1);
      nop(1'b1);
      chk("beq_pcsrc_one_cycle", {7'd0, pcsrc_m[0]}, 8'd0);
      chk("beq_sw_squashed", {7'd0, memwrite_m[0]}, 8'd0);
      nop(1'b0); nop(1'b0); nop(1'b0);

      // not-taken beq
      go(6'h04, 6'h00, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      nop(1'b0);
      nop(1'b0);
      chk("beq_nt_pcsrc", {7'd0, pcsrc_m[0]}, 8'd0);
      chk("beq_nt_flush", {7'd0, flush_d[0]}, 8'd0);
      nop(1'b0); nop(1'b0); nop(1'b0);

      // taken beq in MEM, lw in EXE, dependent add in DEC
      go(6'h04, 6'h00, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      go(6'h23, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      go(6'h00, 6'h20, 5'd2, 5'd5, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0);
      chk("br_over_stall_stall", {7'd0, stall_f[0]}, 8'd0);
      chk("br_over_stall_flush", {7'd0, flush_d[0]}, 8'd1);
      chk("br_over_stall_pcsrc", {7'd0, pcsrc_m[1]}, 8'd1);
      nop(1'b0); nop(1'b0); nop(1'b0);

      // jump, then jump blocked by load-use stall
      go(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("jump_decoded", {7'd0, jump_d[0]}, 8'd1);
      chk("jump_flush", {7'd0, flush_d[0]}, 8'd1);
      go(6'h23, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      go(6'h02, 6'h00, 5'd2, 5'd0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("jump_stall_noflush", {7'd0, flush_d[0]}, 8'd0);
      chk("jump_stall_stall", {7'd0, stall_d[0]}, 8'd1);
      nop(1'b0); nop(1'b0); nop(1'b0);

      // reset mid-stream
      go(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      go(6'h23, 6'h00, 5'd1, 5'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      go(6'h3f, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      nop(1'b0);
      chk("midreset_regwrite_WB", {7'd0, regwrite_w[0]}, 8'd0);
      chk("midreset_stage_regs",
          {2'd0, alusrc_e[0], regdst_e[0], memwrite_m[0], memtoreg_w[0], aluc_e[0][1:0]}, 8'd0);

      // randomized stream, small register range to provoke hazards
      for (int n = 0; n < 1500; n++) begin
         go(($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)],
            ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
